// File: rtl/sobel_gradient.sv
// sobel_gradient: 3-stage signed Sobel Gx/Gy over a sliding 3x3 window, flagging only
// windows that lie wholly inside one frame.
module sobel_gradient #(
    parameter  int IN_WIDTH        = 4,
    parameter  int PIXLES_PER_LINE = 4,
    parameter  int LINES_PER_FRAME = 4,
    localparam int OUT_WIDTH       = IN_WIDTH + 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        frame_start,
    input  logic [9*IN_WIDTH-1:0]       window_in,
    output logic signed [OUT_WIDTH-1:0] grad_x,
    output logic signed [OUT_WIDTH-1:0] grad_y,
    output logic                        out_valid,
    output logic                        out_sof,
    output logic                        out_eol
);
    localparam int SW = IN_WIDTH + 2;
    localparam int CW = $clog2(PIXLES_PER_LINE);
    localparam int RW = $clog2(LINES_PER_FRAME);
    localparam logic [CW-1:0] COL_LAST = CW'(PIXLES_PER_LINE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(LINES_PER_FRAME - 1);

    logic [IN_WIDTH-1:0] p [3][3];
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic interior;
    logic s0_v_q, s0_v_d, s0_sof_q, s0_sof_d, s0_eol_q, s0_eol_d;
    logic s1_v_q, s1_v_d, s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d;
    logic [SW-1:0] gxp_q, gxp_d, gxn_q, gxn_d, gyp_q, gyp_d, gyn_q, gyn_d;
    logic signed [OUT_WIDTH-1:0] grad_x_q, grad_x_d, grad_y_q, grad_y_d;
    logic out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eol_q, out_eol_d;

    function automatic logic [SW-1:0] wsum(input logic [IN_WIDTH-1:0] a, b, c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    always_comb begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r][c] = window_in[(3*r+c)*IN_WIDTH +: IN_WIDTH];
        col_d = col_q;
        row_d = row_q;
        if (en && frame_start) begin
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            row_d = (col_q != COL_LAST) ? row_q : (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end
        // Counters hold the newest pixel; the window is interior once two full rows/cols precede it
        interior = en && (row_d >= RW'(2)) && (col_d >= CW'(2));
        s0_v_d   = interior;
        s0_sof_d = interior && (row_d == RW'(2)) && (col_d == CW'(2));
        s0_eol_d = interior && (col_d == COL_LAST);
        s1_v_d   = s0_v_q;
        s1_sof_d = s0_sof_q;
        s1_eol_d = s0_eol_q;
        gxp_d = wsum(p[0][0], p[1][0], p[2][0]);
        gxn_d = wsum(p[0][2], p[1][2], p[2][2]);
        gyp_d = wsum(p[0][0], p[0][1], p[0][2]);
        gyn_d = wsum(p[2][0], p[2][1], p[2][2]);
        grad_x_d = s1_v_q ? $signed({1'b0, gxp_q}) - $signed({1'b0, gxn_q}) : grad_x_q;
        grad_y_d = s1_v_q ? $signed({1'b0, gyp_q}) - $signed({1'b0, gyn_q}) : grad_y_q;
        out_valid_d = s1_v_q;
        out_sof_d   = s1_v_q && s1_sof_q;
        out_eol_d   = s1_v_q && s1_eol_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= COL_LAST;
            row_q       <= ROW_LAST;
            s0_v_q      <= 1'b0;
            s0_sof_q    <= 1'b0;
            s0_eol_q    <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            gxp_q       <= '0;
            gxn_q       <= '0;
            gyp_q       <= '0;
            gyn_q       <= '0;
            grad_x_q    <= '0;
            grad_y_q    <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            s0_v_q      <= s0_v_d;
            s0_sof_q    <= s0_sof_d;
            s0_eol_q    <= s0_eol_d;
            s1_v_q      <= s1_v_d;
            s1_sof_q    <= s1_sof_d;
            s1_eol_q    <= s1_eol_d;
            gxp_q       <= gxp_d;
            gxn_q       <= gxn_d;
            gyp_q       <= gyp_d;
            gyn_q       <= gyn_d;
            grad_x_q    <= grad_x_d;
            grad_y_q    <= grad_y_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
        end
    end

    assign grad_x    = grad_x_q;
    assign grad_y    = grad_y_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
endmodule

// File: tb/tb_sobel_gradient.sv
// tb_sobel_gradient: streams frames through a modelled sliding window and checks each
// gradient pulse against a queue of expected results and per-frame table constants.
module tb_sobel_gradient;
    localparam int W = 4, P = 4, L = 4, OW = W + 3, HN = 2*P + 3;

    typedef struct { int due; int gx; int gy; bit sof; bit eol; } exp_t;
    typedef struct { int pat; int idle; int pulses; bit uni; int gx; int gy; } vec_t;

    logic clk = 0, rst_n = 0, en = 0, frame_start = 0;
    logic [9*W-1:0] window_in = '0;
    logic signed [OW-1:0] grad_x, grad_y;
    logic out_valid, out_sof, out_eol;

    int checks = 0, passed = 0, edge_n = 0, next_k = 0, last_gx = 0, last_gy = 0;
    int n_pulse = 0, n_sof = 0, n_eol = 0, uni_gx = 0, uni_gy = 0;
    bit uni = 0;
    int hist[$];
    exp_t expq[$];

    sobel_gradient #(.IN_WIDTH(W), .PIXLES_PER_LINE(P), .LINES_PER_FRAME(L)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .frame_start(frame_start), .window_in(window_in),
        .grad_x(grad_x), .grad_y(grad_y), .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    endtask

    function automatic int px(int r, int c);
        return hist[r*P + c];
    endfunction

    function automatic int pix_of(int pat, int r, int c);
        case (pat)
            0: return 9;
            1: return c;
            2: return r;
            3: return (c >= 2) ? 15 : 0;
            4: return (c < 2) ? 15 : 0;
            default: return int'($urandom_range(15));
        endcase
    endfunction

    // Frame position is simply the accept count since the last frame start.
    task automatic accept(bit fs, int pix);
        int k, row, col;
        exp_t e;
        hist.push_front(pix);
        void'(hist.pop_back());
        k = fs ? 0 : next_k;
        next_k = k + 1;
        col = k % P;
        row = (k / P) % L;
        if (row >= 2 && col >= 2) begin
            e.due = edge_n + 2;
            e.gx  = (px(0,0) + 2*px(1,0) + px(2,0)) - (px(0,2) + 2*px(1,2) + px(2,2));
            e.gy  = (px(0,0) + 2*px(0,1) + px(0,2)) - (px(2,0) + 2*px(2,1) + px(2,2));
            e.sof = (row == 2 && col == 2);
            e.eol = (col == P - 1);
            expq.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (out_valid) begin
            n_pulse++;
            n_sof += int'(out_sof);
            n_eol += int'(out_eol);
            if (expq.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e = expq.pop_front();
                chk("latency", edge_n, e.due);
                chk("grad_x", grad_x, e.gx);
                chk("grad_y", grad_y, e.gy);
                chk("sof", int'(out_sof), int'(e.sof));
                chk("eol", int'(out_eol), int'(e.eol));
                last_gx = e.gx;
                last_gy = e.gy;
                if (uni) begin
                    chk("table_gx", grad_x, uni_gx);
                    chk("table_gy", grad_y, uni_gy);
                end
            end
        end else begin
            chk("idle_flags", int'({out_sof, out_eol}), 0);
            chk("hold_gx", grad_x, last_gx);
            chk("hold_gy", grad_y, last_gy);
            if (expq.size() != 0 && expq[0].due <= edge_n) begin
                chk("missing_valid", 0, 1);
                void'(expq.pop_front());
            end
        end
    endtask

    // Called at a negedge; returns at the following negedge after sampling outputs.
    task automatic step(bit e, bit fs, int pix);
        en = e;
        frame_start = fs;
        @(posedge clk);
        edge_n++;
        if (e) accept(fs, pix);
        @(negedge clk);
        monitor();
        if (e)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    window_in[(3*r+c)*W +: W] = W'(hist[r*P + c]);
    endtask

    task automatic do_reset(int cycles);
        rst_n = 0;
        en = 0;
        frame_start = 0;
        expq.delete();
        next_k = 0;
        last_gx = 0;
        last_gy = 0;
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_gx", grad_x, 0);
        chk("rst_gy", grad_y, 0);
        chk("rst_flags", int'({out_sof, out_eol}), 0);
        repeat (cycles) step(0, 0, 0);
        rst_n = 1;
    endtask

    // Idle cycles carry a random frame_start, which must be ignored without en.
    task automatic run_frame(int pat, int idle);
        for (int r = 0; r < L; r++)
            for (int c = 0; c < P; c++) begin
                while (int'($urandom_range(99)) < idle) step(0, 1'($urandom_range(1)), 0);
                step(1, (r == 0 && c == 0), pix_of(pat, r, c));
            end
    endtask

    task automatic frame_counts(string tag, int pulses);
        repeat (4) step(0, 0, 0);
        chk({tag, "_pulses"}, n_pulse, pulses);
        chk({tag, "_sof"}, n_sof, 1);
        chk({tag, "_eol"}, n_eol, 2);
        n_pulse = 0;
        n_sof = 0;
        n_eol = 0;
    endtask

    initial begin
        vec_t tbl[7];
        tbl[0] = '{0, 0, 4, 1'b1, 0, 0};
        tbl[1] = '{1, 0, 4, 1'b1, 8, 0};
        tbl[2] = '{2, 0, 4, 1'b1, 0, 8};
        tbl[3] = '{3, 0, 4, 1'b1, 60, 0};
        tbl[4] = '{4, 0, 4, 1'b1, -60, 0};
        tbl[5] = '{1, 50, 4, 1'b1, 8, 0};
        tbl[6] = '{5, 30, 4, 1'b0, 0, 0};
        for (int i = 0; i < HN; i++) hist.push_back(0);
        @(negedge clk);
        do_reset(2);
        foreach (tbl[i]) begin
            uni = tbl[i].uni;
            uni_gx = tbl[i].gx;
            uni_gy = tbl[i].gy;
            run_frame(tbl[i].pat, tbl[i].idle);
            frame_counts("table", tbl[i].pulses);
        end
        uni = 0;
        // Reset right after pixel (2,2) is accepted: its result must never appear.
        for (int k = 0; k < 11; k++) step(1, (k == 0), int'($urandom_range(15)));
        do_reset(2);
        n_pulse = 0;
        n_sof = 0;
        n_eol = 0;
        step(1, 0, 3);
        step(1, 0, 5);
        run_frame(5, 20);
        frame_counts("restart", 4);
        for (int f = 0; f < 6; f++) begin
            run_frame(5, int'($urandom_range(60)));
            frame_counts("random", 4);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
